// File: rtl/z80_bus_arbiter.sv
// z80 bus arbiter: shares the z80 address/data/control bus between the CPU core
// and NUM_REQ external DMA-style masters. It asks the z80 for the bus with BUSREQ_L,
// waits for BUSACK_L, and then grants one master at a time in round-robin order.
// After every grant the bus returns to the CPU for a guaranteed gap.
module z80_bus_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int MAX_HOLD   = 16,
  parameter int GAP_CYCLES = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ-1:0]         done,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [$clog2(NUM_REQ)-1:0] cur_id,
  output logic                       bus_owned,
  output logic                       BUSREQ_L,
  input  logic                       BUSACK_L
);

  localparam int ID_W   = $clog2(NUM_REQ);
  localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam int GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((MAX_HOLD > 0) ? (MAX_HOLD - 1) : 0);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);
  localparam logic [ID_W-1:0]   LAST_RST  = ID_W'(NUM_REQ - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_GRANT,
    S_RELEASE,
    S_GAP
  } state_t;

  state_t              state_q, state_d;
  logic                busreq_l_q, busreq_l_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d;
  logic [ID_W-1:0]     cur_id_q, cur_id_d;
  logic                bus_owned_q, bus_owned_d;
  logic [ID_W-1:0]     last_id_q, last_id_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [GAP_W-1:0]    gap_q, gap_d;

  logic [ID_W-1:0]     winner;
  logic                hold_expired;
  logic                release_now;

  // Round-robin pick: first set request after 'last', wrapping modulo NUM_REQ.
  // The caller only uses the result when at least one request is set.
  function automatic logic [ID_W-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                               input logic [ID_W-1:0]    last);
    logic [ID_W-1:0] pick;
    logic [ID_W-1:0] idx;
    logic            found;
    pick  = last;
    found = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = ID_W'((int'(last) + i) % NUM_REQ);
      if (!found && r[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
    return pick;
  endfunction

  assign winner       = rr_pick(req, last_id_q);
  assign hold_expired = (MAX_HOLD != 0) && (hold_q == HOLD_LAST);
  // A grant ends on done or request withdrawal by the owner, on timeout, or when
  // the z80 takes the bus back unexpectedly (BUSACK_L high while granted).
  assign release_now  = done[cur_id_q] | ~req[cur_id_q] | hold_expired | BUSACK_L;

  // Next-state and registered-output computation for the arbitration FSM.
  always_comb begin
    state_d     = state_q;
    busreq_l_d  = busreq_l_q;
    gnt_d       = gnt_q;
    cur_id_d    = cur_id_q;
    bus_owned_d = bus_owned_q;
    last_id_d   = last_id_q;
    hold_d      = hold_q;
    gap_d       = gap_q;
    case (state_q)
      S_IDLE: begin
        busreq_l_d = 1'b1;
        if (|req) begin
          state_d    = S_REQ;
          busreq_l_d = 1'b0;
        end
      end
      S_REQ: begin
        busreq_l_d = 1'b0;
        if (!BUSACK_L) begin
          if (|req) begin
            state_d     = S_GRANT;
            gnt_d       = {{(NUM_REQ-1){1'b0}}, 1'b1} << winner;
            cur_id_d    = winner;
            bus_owned_d = 1'b1;
            last_id_d   = winner;
            hold_d      = '0;
          end else begin
            // Every requester withdrew while we waited: hand the bus straight back.
            state_d    = S_RELEASE;
            busreq_l_d = 1'b1;
          end
        end
      end
      S_GRANT: begin
        hold_d = hold_q + 1'b1;
        if (release_now) begin
          state_d     = S_RELEASE;
          gnt_d       = '0;
          bus_owned_d = 1'b0;
          busreq_l_d  = 1'b1;
        end
      end
      S_RELEASE: begin
        busreq_l_d = 1'b1;
        if (BUSACK_L) begin
          state_d = S_GAP;
          gap_d   = '0;
        end
      end
      S_GAP: begin
        busreq_l_d = 1'b1;
        if (gap_q == GAP_LAST) begin
          state_d = S_IDLE;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: begin
        state_d     = S_IDLE;
        busreq_l_d  = 1'b1;
        gnt_d       = '0;
        bus_owned_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset releases the bus immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      busreq_l_q  <= 1'b1;
      gnt_q       <= '0;
      cur_id_q    <= '0;
      bus_owned_q <= 1'b0;
      last_id_q   <= LAST_RST;
      hold_q      <= '0;
      gap_q       <= '0;
    end else begin
      state_q     <= state_d;
      busreq_l_q  <= busreq_l_d;
      gnt_q       <= gnt_d;
      cur_id_q    <= cur_id_d;
      bus_owned_q <= bus_owned_d;
      last_id_q   <= last_id_d;
      hold_q      <= hold_d;
      gap_q       <= gap_d;
    end
  end

  assign gnt       = gnt_q;
  assign cur_id    = cur_id_q;
  assign bus_owned = bus_owned_q;
  assign BUSREQ_L  = busreq_l_q;

endmodule
